// File: rtl/decoder_3x8_seq_if.sv
// Handshake bundle for decoder_3x8_seq: input code channel, scan control and decoded output channel.
// The decoder sits on the slave side; the master modport drives codes and consumes beats.
interface decoder_3x8_seq_if;
    logic       en;
    logic       in_valid;
    logic [2:0] din;
    logic       in_ready;
    logic       scan_start;
    logic [7:0] dout;
    logic       dout_valid;
    logic       out_ready;
    logic       busy;
    logic       scan_done;

    modport master (
        output en, in_valid, din, scan_start, out_ready,
        input  in_ready, dout, dout_valid, busy, scan_done
    );

    modport slave (
        input  en, in_valid, din, scan_start, out_ready,
        output in_ready, dout, dout_valid, busy, scan_done
    );
endinterface

// File: rtl/decoder_3x8_seq.sv
// 3-to-8 one-hot decoder with a single registered output stage and an automatic 0..7 sweep,
// optionally spaced by SCAN_GAP idle cycles between scan beats.
module decoder_3x8_seq #(
    parameter int unsigned SCAN_GAP = 0
) (
    input logic                 clk,
    input logic                 rst_n,
    decoder_3x8_seq_if.slave    bus
);

    typedef enum logic [1:0] {StIdle, StScan, StGap} state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic [3:0] gap_q, gap_d;
    logic [7:0] dout_q, dout_d;
    logic       dout_valid_q, dout_valid_d;

    logic       can_take, consume, in_ready, ld_in, ld_scan, load;
    logic [2:0] code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            last_q       <= 1'b0;
            gap_q        <= 4'd0;
            dout_q       <= 8'h00;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            gap_q        <= gap_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gap_d   = gap_q;
        unique case (state_q)
            StIdle: begin
                if (bus.scan_start) begin
                    state_d = StScan;
                    cnt_d   = 3'd0;
                    last_d  = 1'b0;
                end
            end
            StScan: begin
                // Once code 7 is out, wait for it to drain before returning to idle.
                if (last_q) begin
                    if (consume) begin
                        state_d = StIdle;
                        last_d  = 1'b0;
                    end
                end else if (ld_scan) begin
                    if (cnt_q == 3'd7) begin
                        last_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        if (SCAN_GAP > 0) begin
                            state_d = StGap;
                            gap_d   = 4'(SCAN_GAP - 1);
                        end
                    end
                end
            end
            StGap: begin
                if (gap_q == 4'd0) state_d = StScan;
                else               gap_d   = gap_q - 4'd1;
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            dout_d       = bus.en ? (8'd1 << code) : 8'h00;
            dout_valid_d = 1'b1;
        end else if (consume) begin
            dout_d       = 8'h00;
            dout_valid_d = 1'b0;
        end else begin
            dout_d       = dout_q;
            dout_valid_d = dout_valid_q;
        end
    end

    always_comb begin
        can_take = !dout_valid_q || bus.out_ready;
        consume  = dout_valid_q && bus.out_ready;
        // rst_n gating keeps in_ready low while held in reset.
        in_ready = rst_n && (state_q == StIdle) && !bus.scan_start && can_take;
        ld_in    = bus.in_valid && in_ready;
        ld_scan  = (state_q == StScan) && !last_q && can_take;
        load     = ld_in || ld_scan;
        code     = ld_scan ? cnt_q : bus.din;
    end

    assign bus.in_ready   = in_ready;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.scan_done  = (state_q == StScan) && last_q && consume;

endmodule

// File: doc/decoder_3x8_seq.md
DECODER_3X8_SEQ -- requirements
Module: decoder_3x8_seq

Interface
REQ-001 Parameter SCAN_GAP, default 0: idle cycles inserted between consecutive scan beats (0..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  decode enable; sampled when a beat is loaded.
REQ-005 in_valid  input  1  din holds a code to decode.
REQ-006 din  input  3  binary code 0..7.
REQ-007 in_ready  output  1  block accepts din this cycle.
REQ-008 scan_start  input  1  request automatic sweep of codes 0..7.
REQ-009 dout  output  8  one-hot decoded word.
REQ-010 dout_valid  output  1  dout holds an unconsumed beat.
REQ-011 out_ready  input  1  downstream consumes dout this cycle.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 scan_done  output  1  one-cycle pulse after the last scan beat is consumed.

Function
REQ-014 Single-entry registered output stage; a beat is loaded into dout/dout_valid at the clock edge.
REQ-015 Loaded value: en=1 -> dout = 8'b1 << code; en=0 -> dout = 8'h00, dout_valid still asserted.
REQ-016 Input accept: in_valid && in_ready at edge N -> dout/dout_valid visible after edge N (latency 1 cycle).
REQ-017 in_ready = (state==IDLE) && !scan_start && (!dout_valid || out_ready); no combinational path from in_valid or din.
REQ-018 Backpressure: dout_valid && !out_ready -> dout and dout_valid hold unchanged.
REQ-019 Consume without replacement: dout_valid && out_ready with no new load -> dout_valid=0, dout=8'h00.
REQ-020 Simultaneous consume and load -> new beat replaces old in the same edge, no bubble.
REQ-021 States: IDLE, SCAN, GAP; busy = (state != IDLE).
REQ-022 IDLE -> SCAN when scan_start=1; scan counter cleared to 0; scan_start takes priority over in_valid (no input accepted that cycle).
REQ-023 scan_start ignored outside IDLE.
REQ-024 SCAN: load code = counter when (!dout_valid || out_ready); after load, counter increments; in_ready=0 throughout.
REQ-025 SCAN_GAP>0: after each scan load, state GAP for SCAN_GAP cycles, then SCAN; SCAN_GAP=0 -> back-to-back loads.
REQ-026 After code 7 is loaded, no further loads; when that beat is consumed, scan_done pulses one cycle and state -> IDLE on the same edge.
REQ-027 Counter is 3 bits plus a last-beat flag; no wrap to code 0 within one sweep.
REQ-028 en changes mid-scan affect only beats loaded after the change.

Reset
REQ-029 rst_n=0 asynchronously forces: state=IDLE, dout=8'h00, dout_valid=0, scan_done=0, busy=0, scan counter=0, gap counter=0; in_ready=1 while rst_n=0 is not required (in_ready=0 during reset).
REQ-030 Reset mid-scan aborts the sweep; no scan_done pulse is produced; after release, block is in IDLE with in_ready=1.

Verification
REQ-031 en=1, out_ready=1, din swept 0..7 one per cycle with in_valid=1 -> dout = 01,02,04,...,80 each one cycle after acceptance, dout_valid continuous.
REQ-032 en=0, din=5 accepted -> next cycle dout=8'h00, dout_valid=1; then en=1, din=5 -> dout=8'h20.
REQ-033 din=3 accepted, out_ready=0 for 4 cycles -> dout=8'h08 held, in_ready=0, no new beat; out_ready=1 -> consumed, in_ready=1.
REQ-034 SCAN_GAP=2, scan_start pulse, out_ready=1 -> busy=1, dout 01..80 each separated by 2 idle cycles, scan_done one-cycle pulse when 8'h80 consumed, busy=0 next cycle.
REQ-035 scan_start and in_valid (din=6) asserted together in IDLE -> input not accepted, first beat dout=8'h01.
REQ-036 rst_n pulled low after scan beat 8'h08 loaded -> dout=8'h00, dout_valid=0, busy=0 immediately, no scan_done; after release, din=2 accepted -> dout=8'h04.
